// File: rtl/tl_cntr_timed_left_if.sv
// Sensor and lamp bundle for the timed two-street controller with left phases.
// The intersection side (sensors in, lamps out) uses the slave modport.
interface tl_cntr_timed_left_if;
  logic       Ta;
  logic       Tal;
  logic       Tb;
  logic       Tbl;
  logic [1:0] La;
  logic [1:0] Lal;
  logic [1:0] Lb;
  logic [1:0] Lbl;
  logic [2:0] phase;

  modport master (
    output Ta, Tal, Tb, Tbl,
    input  La, Lal, Lb, Lbl, phase
  );

  modport slave (
    input  Ta, Tal, Tb, Tbl,
    output La, Lal, Lb, Lbl, phase
  );
endinterface

// File: rtl/tl_cntr_timed_left.sv
// Two-street traffic light controller with protected left-turn phases,
// dwell timer, min/max green limits, fixed yellows and rest-in-green.
// Moore machine: every lamp is decoded from the registered state.
//
// state  | meaning
// A_GRN  | street A through green (rests here while B has no demand)
// A_YEL  | street A through yellow, exactly YEL_CYC cycles
// A_LGRN | street A left arrow green, MIN_LEFT..MAX_LEFT cycles
// A_LYEL | street A left arrow yellow, exactly YEL_CYC cycles
// B_GRN  | street B through green (rests here while A has no demand)
// B_YEL  | street B through yellow
// B_LGRN | street B left arrow green
// B_LYEL | street B left arrow yellow, then back to A_GRN
module tl_cntr_timed_left #(
  parameter int CNT_W    = 8,
  parameter int MIN_GRN  = 4,
  parameter int MAX_GRN  = 10,
  parameter int YEL_CYC  = 2,
  parameter int MIN_LEFT = 2,
  parameter int MAX_LEFT = 5,
  parameter int LEFT_EN  = 1
) (
  input logic               clk,
  input logic               reset,
  tl_cntr_timed_left_if.slave bus
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    A_LGRN = 3'd2,
    A_LYEL = 3'd3,
    B_GRN  = 3'd4,
    B_YEL  = 3'd5,
    B_LGRN = 3'd6,
    B_LYEL = 3'd7
  } state_t;

  localparam logic [1:0] LAMP_GRN = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_RED = 2'b10;

  // Thresholds are compared against t, which starts at 0 in a state's first cycle.
  localparam logic [CNT_W-1:0] MIN_GRN_T  = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] MAX_GRN_T  = CNT_W'(MAX_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_T      = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LEFT_T = CNT_W'(MIN_LEFT - 1);
  localparam logic [CNT_W-1:0] MAX_LEFT_T = CNT_W'(MAX_LEFT - 1);
  localparam logic             LEFT_ON    = (LEFT_EN != 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] t;
  logic             dem_a;
  logic             dem_b;

  // Demand seen by the green street comes from the other street's sensors.
  assign dem_a = bus.Tb | bus.Tbl;
  assign dem_b = bus.Ta | bus.Tal;

  // State register and dwell timer; timer restarts on every state change and saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= A_GRN;
      t     <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        t <= '0;
      end else if (t != {CNT_W{1'b1}}) begin
        t <= t + 1'b1;
      end
    end
  end

  // Next-state decision from the current state, dwell time and sensors.
  always_comb begin
    state_nxt = state;
    case (state)
      A_GRN: begin
        if (dem_a && (t >= MIN_GRN_T) && (!bus.Ta || (t >= MAX_GRN_T))) state_nxt = A_YEL;
      end
      A_YEL: begin
        if (t == YEL_T) state_nxt = (LEFT_ON && bus.Tal) ? A_LGRN : B_GRN;
      end
      A_LGRN: begin
        if ((t >= MIN_LEFT_T) && (!bus.Tal || (t >= MAX_LEFT_T))) state_nxt = A_LYEL;
      end
      A_LYEL: begin
        if (t == YEL_T) state_nxt = B_GRN;
      end
      B_GRN: begin
        if (dem_b && (t >= MIN_GRN_T) && (!bus.Tb || (t >= MAX_GRN_T))) state_nxt = B_YEL;
      end
      B_YEL: begin
        if (t == YEL_T) state_nxt = (LEFT_ON && bus.Tbl) ? B_LGRN : A_GRN;
      end
      B_LGRN: begin
        if ((t >= MIN_LEFT_T) && (!bus.Tbl || (t >= MAX_LEFT_T))) state_nxt = B_LYEL;
      end
      B_LYEL: begin
        if (t == YEL_T) state_nxt = A_GRN;
      end
      default: state_nxt = A_GRN;
    endcase
  end

  // Lamp decode: only the lamp named by the state is lit, everything else red.
  always_comb begin
    bus.La    = LAMP_RED;
    bus.Lal   = LAMP_RED;
    bus.Lb    = LAMP_RED;
    bus.Lbl   = LAMP_RED;
    bus.phase = state;
    case (state)
      A_GRN:  bus.La  = LAMP_GRN;
      A_YEL:  bus.La  = LAMP_YEL;
      A_LGRN: bus.Lal = LAMP_GRN;
      A_LYEL: bus.Lal = LAMP_YEL;
      B_GRN:  bus.Lb  = LAMP_GRN;
      B_YEL:  bus.Lb  = LAMP_YEL;
      B_LGRN: bus.Lbl = LAMP_GRN;
      B_LYEL: bus.Lbl = LAMP_YEL;
      default: begin
        bus.La    = LAMP_GRN;
        bus.phase = 3'd0;
      end
    endcase
  end

endmodule
